// File: rtl/case_2_mul_pipe_sat.sv
// Pipelined multiplier with per-operand signedness, optional saturation and valid tracking.
// The exact product is formed combinationally, then the narrowed result travels a NUM_STAGE-deep register chain.
module case_2_mul_pipe_sat #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 11,
    parameter int din1_WIDTH  = 5,
    parameter int dout_WIDTH  = 13,
    parameter int din0_SIGNED = 1,
    parameter int din1_SIGNED = 1,
    parameter int SAT         = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH + 2;
    localparam int CW = ((PW > dout_WIDTH) ? PW : dout_WIDTH) + 2;
    localparam bit RES_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] MAX_C = RES_SIGNED ? ((ONE_C << (dout_WIDTH - 1)) - ONE_C)
                                                 : ((ONE_C << dout_WIDTH) - ONE_C);
    localparam logic [CW-1:0] MIN_C = RES_SIGNED ? (~(ONE_C << (dout_WIDTH - 1)) + ONE_C)
                                                 : {CW{1'b0}};
    localparam logic [dout_WIDTH-1:0] DOUT_MAX = MAX_C[dout_WIDTH-1:0];
    localparam logic [dout_WIDTH-1:0] DOUT_MIN = MIN_C[dout_WIDTH-1:0];

    if ((NUM_STAGE < 1) || (NUM_STAGE > 8) || (ID < 0)) begin : g_bad_param
        $error("case_2_mul_pipe_sat: NUM_STAGE must lie in 1..8 and ID must be non-negative");
    end

    logic                   w_a_sbit;
    logic                   w_b_sbit;
    logic signed [PW-1:0]   w_a_wide;
    logic signed [PW-1:0]   w_b_wide;
    logic signed [PW-1:0]   w_p;
    logic signed [CW-1:0]   w_p_c;
    logic                   w_hi;
    logic                   w_lo;
    logic                   w_ovf;
    logic [dout_WIDTH-1:0]  w_dout;

    logic                   r_vld  [NUM_STAGE];
    logic [dout_WIDTH-1:0]  r_dout [NUM_STAGE];
    logic                   r_ovf  [NUM_STAGE];

    // Unsigned operands get a zero top bit so one signed multiplier covers all four signedness mixes.
    assign w_a_sbit = (din0_SIGNED != 0) ? din0[din0_WIDTH-1] : 1'b0;
    assign w_b_sbit = (din1_SIGNED != 0) ? din1[din1_WIDTH-1] : 1'b0;
    assign w_a_wide = {{(PW-din0_WIDTH){w_a_sbit}}, din0};
    assign w_b_wide = {{(PW-din1_WIDTH){w_b_sbit}}, din1};
    assign w_p      = w_a_wide * w_b_wide;
    assign w_p_c    = {{(CW-PW){w_p[PW-1]}}, w_p};
    assign w_hi     = w_p_c > $signed(MAX_C);
    assign w_lo     = w_p_c < $signed(MIN_C);
    assign w_ovf    = w_hi | w_lo;

    // Narrow the exact product to dout_WIDTH, clamping only when saturation is enabled.
    always_comb begin
        w_dout = w_p_c[dout_WIDTH-1:0];
        if ((SAT != 0) && w_hi) begin
            w_dout = DOUT_MAX;
        end else if ((SAT != 0) && w_lo) begin
            w_dout = DOUT_MIN;
        end else begin
            w_dout = w_p_c[dout_WIDTH-1:0];
        end
    end

    // Valid/data chain: data only moves behind a valid bit, so bubbles leave the last result in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGE; k++) begin
                r_vld[k]  <= 1'b0;
                r_dout[k] <= {dout_WIDTH{1'b0}};
                r_ovf[k]  <= 1'b0;
            end
        end else if (ce) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
                r_dout[0] <= w_dout;
                r_ovf[0]  <= w_ovf;
            end
            for (int k = 1; k < NUM_STAGE; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dout[k] <= r_dout[k-1];
                    r_ovf[k]  <= r_ovf[k-1];
                end
            end
        end
    end

    assign out_valid = r_vld[NUM_STAGE-1];
    assign dout      = r_dout[NUM_STAGE-1];
    assign ovf       = r_ovf[NUM_STAGE-1];

endmodule

// File: doc/case_2_mul_pipe_sat.md
Name: case_2_mul_pipe_sat

Overview:
- Parametrised successor to the HLS combinational signed multiplier cores.
- Multiplies two operands through a NUM_STAGE-deep pipeline. The pipeline supports clock-enable stalls, valid tracking, per-operand signedness and optional saturation of the narrowed result.
- Sits in the generated datapath wherever the scheduler assigns a multi-cycle multiply; drop-in for the mul_*_*_*_1_1 cores when latency > 0.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, pipeline latency in enabled cycles; legal range 1..8; anything else is an elaboration error.
- din0_WIDTH, 11, width of din0.
- din1_WIDTH, 5, width of din1.
- dout_WIDTH, 13, width of dout.
- din0_SIGNED, 1, 1 = din0 is two's complement; 0 = unsigned.
- din1_SIGNED, 1, 1 = din1 is two's complement; 0 = unsigned.
- SAT, 0, 1 = clamp to dout range on overflow; 0 = keep low dout_WIDTH bits (wrap).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes every pipeline register.
- in_valid  in  1  din0/din1 carry an operand pair this cycle.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- out_valid  out  1  dout/ovf carry a result.
- dout  out  dout_WIDTH  product, narrowed per SAT.
- ovf  out  1  full product did not fit in dout range.

Behaviour:
- Reset (async, active-high): all valid bits, data registers, dout, out_valid and ovf go to 0 immediately and stay 0 while reset is high.
- Reset mid-operation: in-flight pairs are discarded; no result ever emerges for them.
- Operand extension: each operand is extended by one bit, sign-extended if its _SIGNED is 1, else zero-extended. The full product P has width din0_WIDTH+din1_WIDTH+2 and is exact.
- Result signedness: result R is signed if din0_SIGNED or din1_SIGNED, else unsigned.
- Range: signed R spans -2^(dout_WIDTH-1)..2^(dout_WIDTH-1)-1; unsigned R spans 0..2^dout_WIDTH-1.
- ovf: 1 when P lies outside that range, independent of SAT.
- dout, SAT=0: the low dout_WIDTH bits of P.
- dout, SAT=1, no overflow: P.
- dout, SAT=1, overflow: max of range if P is too high, min of range if P is too low (0 for unsigned).
- Valid pipeline: NUM_STAGE valid bits. Stage 1 samples in_valid and every stage advances only on clk edges where ce=1.
- Data registers: stage k data loads only when ce=1 and its upstream valid is 1. Bubbles therefore leave dout and ovf holding the last valid result.
- Latency: a pair presented with in_valid=1 on an edge with ce=1 appears with out_valid=1 exactly NUM_STAGE enabled edges later.
- Throughput: one pair per enabled cycle; no backpressure port; ordering is preserved.
- ce=0: in_valid/din are ignored and all outputs hold. A stall of N cycles delays every in-flight result by exactly N cycles, with no loss or duplication.
- Output registers: dout, ovf and out_valid come directly from flops. Internal partition of extend/multiply/saturate across stages is free, provided latency and results match.
- NUM_STAGE=1: extend, multiply and saturate are combinational into the single output register.

Test Plan:
1. Defaults; din0=100, din1=-7, in_valid=1, ce=1 -> 3 edges later out_valid=1, dout=13'h1D44 (-700), ovf=0.
2. SAT=1; din0=-1024, din1=-16 -> dout=13'h0FFF (4095), ovf=1. Repeat with SAT=0 -> dout=13'h0000, ovf=1. Repeat with din0=1023, din1=15 (15345), SAT=1 -> dout=13'h0FFF, ovf=1.
3. din0_SIGNED=0; din0=11'h7FF (2047), din1=5'h1F (-1) -> dout=13'h1801 (-2047), ovf=0. With both unsigned and SAT=1: 2047*31 -> dout=13'h1FFF, ovf=1.
4. Three back-to-back pairs (2*3, 4*5, 6*7); ce low for 2 cycles after the 2nd issue -> results 6, 20, 42 in order; out_valid pulses delayed by exactly 2 cycles vs. the no-stall run; no repeats.
5. Pair (3*3), then in_valid=0 for 4 cycles -> out_valid high one cycle with dout=9, then out_valid=0 while dout stays 9.
6. Reset asserted asynchronously (between edges) with 2 pairs in flight -> outputs 0 immediately; after release no out_valid until a new pair is issued; new pair emerges NUM_STAGE later. Sweep NUM_STAGE=1 and 8 for latency.
